// File: rtl/apb_monitor_checker13_if.sv
// Purpose: bundles the observed APB bus, checker controls and monitor results.
// Ports  : master modport drives the bus/controls and reads results;
//          slave modport is the monitor view (samples bus, drives results).
interface apb_monitor_checker13_if #(
  parameter int PADDR_WIDTH13  = 32,
  parameter int PWDATA_WIDTH13 = 32,
  parameter int PRDATA_WIDTH13 = 32,
  parameter int NUM_SLAVES13   = 16,
  parameter int CNT_WIDTH13    = 16
);
  localparam int XDW13 = (PWDATA_WIDTH13 > PRDATA_WIDTH13) ? PWDATA_WIDTH13 : PRDATA_WIDTH13;

  // Observed APB bus
  logic [PADDR_WIDTH13-1:0]  paddr13;
  logic                      prwd13;
  logic [PWDATA_WIDTH13-1:0] pwdata13;
  logic [PRDATA_WIDTH13-1:0] prdata13;
  logic                      penable13;
  logic                      pready13;
  logic                      pslverr13;
  logic [NUM_SLAVES13-1:0]   psel13;

  // Checker controls
  logic                      has_checks13;
  logic                      err_clr13;

  // Monitor results
  logic [7:0]                err_flags13;
  logic                      err_pulse13;
  logic                      xfer_done13;
  logic                      xfer_write13;
  logic [PADDR_WIDTH13-1:0]  xfer_addr13;
  logic [XDW13-1:0]          xfer_data13;
  logic [3:0]                xfer_slave13;
  logic                      xfer_slverr13;
  logic [CNT_WIDTH13-1:0]    wr_count13;
  logic [CNT_WIDTH13-1:0]    rd_count13;
  logic [CNT_WIDTH13-1:0]    slverr_count13;
  logic [1:0]                state13;

  modport master (
    output paddr13, prwd13, pwdata13, prdata13, penable13, pready13, pslverr13, psel13,
    output has_checks13, err_clr13,
    input  err_flags13, err_pulse13, xfer_done13, xfer_write13, xfer_addr13, xfer_data13,
    input  xfer_slave13, xfer_slverr13, wr_count13, rd_count13, slverr_count13, state13
  );

  modport slave (
    input  paddr13, prwd13, pwdata13, prdata13, penable13, pready13, pslverr13, psel13,
    input  has_checks13, err_clr13,
    output err_flags13, err_pulse13, xfer_done13, xfer_write13, xfer_addr13, xfer_data13,
    output xfer_slave13, xfer_slverr13, wr_count13, rd_count13, slverr_count13, state13
  );
endinterface

// File: rtl/apb_monitor_checker13.sv
// Purpose    : passive APB protocol tracker/checker with transfer reporting and statistics.
// Latency    : every result is registered at the edge that samples the bus (visible the next cycle).
// Backpressure: none; purely observes, never stalls the bus.
// Ports      : pclock13/preset13 plain; bus (slave modport) carries APB inputs, has_checks13,
//              err_clr13, and the err_*/xfer_*/count/state13 outputs.
module apb_monitor_checker13 #(
  parameter int PADDR_WIDTH13  = 32,
  parameter int PWDATA_WIDTH13 = 32,
  parameter int PRDATA_WIDTH13 = 32,
  parameter int NUM_SLAVES13   = 16,
  parameter int TIMEOUT13      = 16,
  parameter int CNT_WIDTH13    = 16
) (
  input  logic                   pclock13,
  input  logic                   preset13,
  apb_monitor_checker13_if.slave bus
);
  localparam int XDW = (PWDATA_WIDTH13 > PRDATA_WIDTH13) ? PWDATA_WIDTH13 : PRDATA_WIDTH13;
  localparam int WW  = $clog2(TIMEOUT13 + 1);
  localparam logic [WW-1:0] TO_VAL = WW'(TIMEOUT13);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [PADDR_WIDTH13-1:0]  paddr_q, paddr_d;
  logic                      prwd_q, prwd_d;
  logic [PWDATA_WIDTH13-1:0] pwdata_q, pwdata_d;
  logic [NUM_SLAVES13-1:0]   psel_q, psel_d;
  logic [WW-1:0]             wait_q, wait_d, wait_inc;
  logic [7:0]                err_flags_q, err_flags_d, err_det;
  logic                      err_pulse_q, err_pulse_d;
  logic                      xfer_done_q, xfer_done_d;
  logic                      xfer_write_q, xfer_write_d;
  logic [PADDR_WIDTH13-1:0]  xfer_addr_q, xfer_addr_d;
  logic [XDW-1:0]            xfer_data_q, xfer_data_d;
  logic [3:0]                xfer_slave_q, xfer_slave_d, slave_idx;
  logic                      xfer_slverr_q, xfer_slverr_d;
  logic [CNT_WIDTH13-1:0]    wr_q, wr_d, rd_q, rd_d, se_q, se_d;
  logic                      sel_any, multi_sel, valid, idle_eval, seq_err, tmo_err, done;

  assign sel_any   = (bus.psel13 != '0);
  // x & (x-1) clears the lowest set bit; anything left means two or more selects.
  assign multi_sel = (NUM_SLAVES13 > 1) &&
                     ((bus.psel13 & (bus.psel13 - NUM_SLAVES13'(1))) != '0);
  // An access sample must repeat exactly what was latched in setup.
  assign valid     = bus.penable13 && (bus.psel13 == psel_q) && (bus.paddr13 == paddr_q) &&
                     (bus.prwd13 == prwd_q) && (!prwd_q || (bus.pwdata13 == pwdata_q));
  assign wait_inc  = wait_q + WW'(1);

  // Transfer tracker
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    prwd_d    = prwd_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    wait_d    = wait_q;
    idle_eval = 1'b0;
    seq_err   = 1'b0;
    tmo_err   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: idle_eval = 1'b1;
      SETUP, ACCESS: begin
        if (valid) begin
          if (bus.pready13) begin
            done    = 1'b1;
            state_d = IDLE;
            wait_d  = '0;
          end else if (wait_inc >= TO_VAL) begin
            // Abandon the transfer: no completion is reported.
            tmo_err = 1'b1;
            state_d = IDLE;
            wait_d  = '0;
          end else begin
            state_d = ACCESS;
            wait_d  = wait_inc;
          end
        end else begin
          // Broken transfer: flag it, then treat this sample as a fresh IDLE sample.
          seq_err   = 1'b1;
          wait_d    = '0;
          idle_eval = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (idle_eval) begin
      state_d = IDLE;
      if (sel_any && !bus.penable13) begin
        state_d  = SETUP;
        paddr_d  = bus.paddr13;
        prwd_d   = bus.prwd13;
        pwdata_d = bus.pwdata13;
        psel_d   = bus.psel13;
      end else if (sel_any && bus.penable13) begin
        seq_err = 1'b1;
      end
    end
  end

  // Lowest set select index of the latched transfer
  always_comb begin
    slave_idx = 4'd0;
    for (int i = NUM_SLAVES13 - 1; i >= 0; i--) begin
      if (psel_q[i]) slave_idx = 4'(i);
    end
  end

  // Error detection, reporting and statistics next-state
  always_comb begin
    err_det = '0;
    if (bus.has_checks13) begin
      err_det[0] = sel_any && $isunknown(bus.paddr13);
      err_det[1] = sel_any && $isunknown(bus.prwd13);
      err_det[2] = sel_any && (bus.prwd13 == 1'b1) && $isunknown(bus.pwdata13);
      err_det[3] = $isunknown(bus.penable13);
      err_det[4] = $isunknown(bus.psel13);
      err_det[5] = multi_sel;
      err_det[6] = seq_err;
      err_det[7] = tmo_err;
    end
    // A clear coinciding with new errors keeps only the new bits.
    err_flags_d   = (bus.err_clr13 ? 8'd0 : err_flags_q) | err_det;
    err_pulse_d   = |err_det;

    xfer_done_d   = done;
    xfer_write_d  = xfer_write_q;
    xfer_addr_d   = xfer_addr_q;
    xfer_data_d   = xfer_data_q;
    xfer_slave_d  = xfer_slave_q;
    xfer_slverr_d = xfer_slverr_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    se_d          = se_q;
    if (done) begin
      xfer_write_d  = prwd_q;
      xfer_addr_d   = paddr_q;
      xfer_data_d   = prwd_q ? XDW'(pwdata_q) : XDW'(bus.prdata13);
      xfer_slave_d  = slave_idx;
      xfer_slverr_d = bus.pslverr13;
      if (prwd_q && (wr_q != '1))  wr_d = wr_q + CNT_WIDTH13'(1);
      if (!prwd_q && (rd_q != '1)) rd_d = rd_q + CNT_WIDTH13'(1);
      if (bus.pslverr13 && (se_q != '1)) se_d = se_q + CNT_WIDTH13'(1);
    end
  end

  always_ff @(posedge pclock13 or negedge preset13) begin
    if (!preset13) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      prwd_q        <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= '0;
      wait_q        <= '0;
      err_flags_q   <= '0;
      err_pulse_q   <= 1'b0;
      xfer_done_q   <= 1'b0;
      xfer_write_q  <= 1'b0;
      xfer_addr_q   <= '0;
      xfer_data_q   <= '0;
      xfer_slave_q  <= '0;
      xfer_slverr_q <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
      se_q          <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      prwd_q        <= prwd_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      wait_q        <= wait_d;
      err_flags_q   <= err_flags_d;
      err_pulse_q   <= err_pulse_d;
      xfer_done_q   <= xfer_done_d;
      xfer_write_q  <= xfer_write_d;
      xfer_addr_q   <= xfer_addr_d;
      xfer_data_q   <= xfer_data_d;
      xfer_slave_q  <= xfer_slave_d;
      xfer_slverr_q <= xfer_slverr_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      se_q          <= se_d;
    end
  end

  assign bus.state13        = state_q;
  assign bus.err_flags13    = err_flags_q;
  assign bus.err_pulse13    = err_pulse_q;
  assign bus.xfer_done13    = xfer_done_q;
  assign bus.xfer_write13   = xfer_write_q;
  assign bus.xfer_addr13    = xfer_addr_q;
  assign bus.xfer_data13    = xfer_data_q;
  assign bus.xfer_slave13   = xfer_slave_q;
  assign bus.xfer_slverr13  = xfer_slverr_q;
  assign bus.wr_count13     = wr_q;
  assign bus.rd_count13     = rd_q;
  assign bus.slverr_count13 = se_q;
endmodule

// File: tb/tb_apb_monitor_checker13.sv
// Purpose    : directed bench for apb_monitor_checker13 with a transfer scoreboard.
// Latency    : outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a; the bench plays the APB master and slave.
module tb_apb_monitor_checker13;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_monitor_checker13_if #(.CNT_WIDTH13(CW)) bus ();

  apb_monitor_checker13 #(.TIMEOUT13(4), .CNT_WIDTH13(CW)) dut (
    .pclock13(clk),
    .preset13(rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  slave;
    logic        serr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_done   = 0;
  int   exp_wr   = 0;
  int   exp_rd   = 0;
  int   exp_se   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // One clock; any reported completion is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.xfer_done13 === 1'b1) begin
      n_done++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("xfer_write",  64'(bus.xfer_write13),  64'(e.w));
        chk("xfer_addr",   64'(bus.xfer_addr13),   64'(e.addr));
        chk("xfer_data",   64'(bus.xfer_data13),   64'(e.data));
        chk("xfer_slave",  64'(bus.xfer_slave13),  64'(e.slave));
        chk("xfer_slverr", 64'(bus.xfer_slverr13), 64'(e.serr));
      end
    end
  endtask

  task automatic expect_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic serr);
    exp_t e;
    e.w = w; e.addr = a; e.data = d; e.slave = s; e.serr = serr;
    exp_q.push_back(e);
    n_push++;
    if (w) exp_wr = sat(exp_wr); else exp_rd = sat(exp_rd);
    if (serr) exp_se = sat(exp_se);
  endtask

  task automatic idle();
    bus.psel13 = '0; bus.penable13 = 1'b0; bus.pready13 = 1'b0; bus.pslverr13 = 1'b0;
    tick();
  endtask

  task automatic setup(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [15:0] s);
    bus.psel13 = s; bus.paddr13 = a; bus.prwd13 = w; bus.pwdata13 = d;
    bus.penable13 = 1'b0; bus.pready13 = 1'b0; bus.pslverr13 = 1'b0;
    tick();
  endtask

  task automatic access(input logic rdy, input logic [31:0] rd, input logic serr);
    bus.penable13 = 1'b1; bus.pready13 = rdy; bus.prdata13 = rd; bus.pslverr13 = serr;
    tick();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_wr"}, 64'(bus.wr_count13),     64'(exp_wr));
    chk({tag, "_rd"}, 64'(bus.rd_count13),     64'(exp_rd));
    chk({tag, "_se"}, 64'(bus.slverr_count13), 64'(exp_se));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},  64'(bus.state13),       64'd0);
    chk({tag, "_flags"},  64'(bus.err_flags13),   64'd0);
    chk({tag, "_pulse"},  64'(bus.err_pulse13),   64'd0);
    chk({tag, "_done"},   64'(bus.xfer_done13),   64'd0);
    chk({tag, "_write"},  64'(bus.xfer_write13),  64'd0);
    chk({tag, "_addr"},   64'(bus.xfer_addr13),   64'd0);
    chk({tag, "_data"},   64'(bus.xfer_data13),   64'd0);
    chk({tag, "_slave"},  64'(bus.xfer_slave13),  64'd0);
    chk({tag, "_slverr"}, 64'(bus.xfer_slverr13), 64'd0);
    check_counts(tag);
  endtask

  initial begin
    bus.paddr13 = '0; bus.prwd13 = 1'b0; bus.pwdata13 = '0; bus.prdata13 = '0;
    bus.penable13 = 1'b0; bus.pready13 = 1'b0; bus.pslverr13 = 1'b0; bus.psel13 = '0;
    bus.has_checks13 = 1'b1; bus.err_clr13 = 1'b0;

    // Reset state
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero-wait write to slave 2
    setup(32'h10, 1'b1, 32'hA5, 16'h0004);
    chk("wr_setup_state", 64'(bus.state13), 64'd1);
    expect_xfer(1'b1, 32'h10, 32'hA5, 4'd2, 1'b0);
    access(1'b1, 32'h0, 1'b0);
    chk("wr_done", 64'(bus.xfer_done13), 64'd1);
    chk("wr_state_idle", 64'(bus.state13), 64'd0);
    chk("wr_flags", 64'(bus.err_flags13), 64'd0);
    check_counts("wr");
    idle();
    chk("wr_done_one_cycle", 64'(bus.xfer_done13), 64'd0);
    chk("wr_addr_held", 64'(bus.xfer_addr13), 64'h10);

    // Read with three wait cycles and a slave error
    setup(32'h20, 1'b0, 32'h0, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 32'hDEAD, 1'b0);
      chk("rd_wait_state", 64'(bus.state13), 64'd2);
      chk("rd_wait_nodone", 64'(bus.xfer_done13), 64'd0);
    end
    expect_xfer(1'b0, 32'h20, 32'h1234, 4'd8, 1'b1);
    access(1'b1, 32'h1234, 1'b1);
    chk("rd_done", 64'(bus.xfer_done13), 64'd1);
    check_counts("rd");
    idle();
    chk("rd_data_held", 64'(bus.xfer_data13), 64'h1234);

    // Back-to-back transfers
    setup(32'h30, 1'b1, 32'h11, 16'h8000);
    expect_xfer(1'b1, 32'h30, 32'h11, 4'd15, 1'b0);
    access(1'b1, 32'h0, 1'b0);
    setup(32'h34, 1'b1, 32'h22, 16'h0001);
    chk("b2b_setup_state", 64'(bus.state13), 64'd1);
    chk("b2b_no_err", 64'(bus.err_flags13), 64'd0);
    expect_xfer(1'b1, 32'h34, 32'h22, 4'd0, 1'b0);
    access(1'b1, 32'h0, 1'b0);
    check_counts("b2b");
    idle();

    // Multiple selects; completion still reported with the lowest index
    setup(32'h38, 1'b1, 32'h33, 16'h0006);
    chk("multi_flags", 64'(bus.err_flags13), 64'h20);
    chk("multi_pulse", 64'(bus.err_pulse13), 64'd1);
    expect_xfer(1'b1, 32'h38, 32'h33, 4'd1, 1'b0);
    access(1'b1, 32'h0, 1'b0);
    idle();
    chk("multi_pulse_drop", 64'(bus.err_pulse13), 64'd0);
    chk("multi_sticky", 64'(bus.err_flags13), 64'h20);
    // Clear together with a fresh sequence violation keeps only the new bit
    bus.err_clr13 = 1'b1; bus.psel13 = 16'h0001; bus.penable13 = 1'b1;
    tick();
    chk("clr_with_new", 64'(bus.err_flags13), 64'h40);
    bus.err_clr13 = 1'b1;
    idle();
    bus.err_clr13 = 1'b0;
    chk("clr_flags", 64'(bus.err_flags13), 64'd0);

    // Address changes between setup and access
    setup(32'h40, 1'b0, 32'h0, 16'h0002);
    bus.paddr13 = 32'h44;
    access(1'b1, 32'h55, 1'b0);
    chk("addr_chg_flags", 64'(bus.err_flags13), 64'h40);
    chk("addr_chg_nodone", 64'(bus.xfer_done13), 64'd0);
    chk("addr_chg_state", 64'(bus.state13), 64'd0);
    bus.err_clr13 = 1'b1;
    idle();
    bus.err_clr13 = 1'b0;

    // Timeout with checks on, then with checks off
    for (int pass = 0; pass < 2; pass++) begin
      bus.has_checks13 = (pass == 0);
      setup(32'h50, 1'b0, 32'h0, 16'h0010);
      for (int i = 0; i < 3; i++) access(1'b0, 32'h0, 1'b0);
      chk("tmo_pre_state", 64'(bus.state13), 64'd2);
      chk("tmo_pre_flags", 64'(bus.err_flags13), 64'd0);
      access(1'b0, 32'h0, 1'b0);
      chk("tmo_state", 64'(bus.state13), 64'd0);
      chk("tmo_flags", 64'(bus.err_flags13), (pass == 0) ? 64'h80 : 64'h0);
      chk("tmo_pulse", 64'(bus.err_pulse13), (pass == 0) ? 64'd1 : 64'd0);
      chk("tmo_nodone", 64'(bus.xfer_done13), 64'd0);
      idle();
      bus.err_clr13 = 1'b1;
      idle();
      bus.err_clr13 = 1'b0;
    end
    bus.has_checks13 = 1'b0;
    bus.psel13 = 16'h0001; bus.penable13 = 1'b1;
    tick();
    chk("nochk_seq_flags", 64'(bus.err_flags13), 64'd0);
    bus.has_checks13 = 1'b1;
    idle();

    // Read and slave-error counters saturate
    for (int i = 0; i < 7; i++) begin
      setup(32'h100 + 32'(i), 1'b0, 32'h0, 16'h0020);
      expect_xfer(1'b0, 32'h100 + 32'(i), 32'h900 + 32'(i), 4'd5, 1'b1);
      access(1'b1, 32'h900 + 32'(i), 1'b1);
      check_counts("sat");
    end
    idle();

    // Reset during ACCESS abandons the transfer
    setup(32'h60, 1'b1, 32'h77, 16'h0020);
    access(1'b0, 32'h0, 1'b0);
    chk("rst_pre_state", 64'(bus.state13), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_wr = 0; exp_rd = 0; exp_se = 0;
    check_reset_outputs("midrst");
    bus.psel13 = '0; bus.penable13 = 1'b0; bus.pready13 = 1'b0;
    #2;
    rst_n = 1'b1;
    idle();
    chk("post_rst_nodone", 64'(bus.xfer_done13), 64'd0);
    chk("post_rst_flags", 64'(bus.err_flags13), 64'd0);
    setup(32'h70, 1'b0, 32'h0, 16'h0040);
    expect_xfer(1'b0, 32'h70, 32'hBEEF, 4'd6, 1'b0);
    access(1'b1, 32'hBEEF, 1'b0);
    check_counts("post_rst");
    idle();

    chk("done_count", 64'(n_done), 64'(n_push));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
